// File: rtl/add32_seq_pkg.sv
// Width constants for the sequential 32-bit adder/subtractor.
// State encodings stay local to add32_seq.
package add32_seq_pkg;
   localparam int unsigned OP_W   = 32;
   localparam int unsigned HALF_W = 16;
endpackage

// File: rtl/add32_seq_rca_16.sv
// 16-bit ripple-carry adder with carry-out and signed-overflow flags.
// The sequential top reuses it for both halves of the 32-bit operation.
module rca_16
   import add32_seq_pkg::*;
(
   input  logic [HALF_W-1:0] i_a,
   input  logic [HALF_W-1:0] i_b,
   input  logic              i_cin,
   output logic [HALF_W-1:0] o_sum,
   output logic              o_cout,
   output logic              o_ovf
);
   logic [HALF_W:0] w_c;

   assign w_c[0] = i_cin;

   genvar gi;
   generate
      for (gi = 0; gi < HALF_W; gi = gi + 1) begin : g_bit
         assign o_sum[gi]  = i_a[gi] ^ i_b[gi] ^ w_c[gi];
         assign w_c[gi+1]  = (i_a[gi] & i_b[gi]) | (w_c[gi] & (i_a[gi] ^ i_b[gi]));
      end
   endgenerate

   assign o_cout = w_c[HALF_W];
   // Signed overflow: carry into the MSB differs from carry out of it.
   assign o_ovf  = w_c[HALF_W-1] ^ w_c[HALF_W];
endmodule

// File: rtl/add32_seq.sv
// Sequential 32-bit add/subtract: one shared 16-bit adder, low half then high half.
// Valid/ready handshake on both sides; one operation in flight at a time.
module add32_seq
   import add32_seq_pkg::*;
(
   input  logic            clock,
   input  logic            reset_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [OP_W-1:0] operand_a,
   input  logic [OP_W-1:0] operand_b,
   input  logic            sub,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [OP_W-1:0] result,
   output logic            cout,
   output logic            overflow
);
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LO   = 2'd1,
      ST_HI   = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   state_t            r_state;
   logic [OP_W-1:0]   r_a;
   logic [OP_W-1:0]   r_b;
   logic              r_cin;
   logic              r_carry;
   logic [OP_W-1:0]   r_result;
   logic              r_cout;
   logic              r_ovf;
   logic              r_out_valid;
   logic              r_in_ready;

   logic [HALF_W-1:0] w_add_a;
   logic [HALF_W-1:0] w_add_b;
   logic              w_add_cin;
   logic [HALF_W-1:0] w_sum;
   logic              w_cout;
   logic              w_ovf;

   // Operand half and carry-in are steered by state into the single adder.
   assign w_add_a   = (r_state == ST_HI) ? r_a[OP_W-1:HALF_W] : r_a[HALF_W-1:0];
   assign w_add_b   = (r_state == ST_HI) ? r_b[OP_W-1:HALF_W] : r_b[HALF_W-1:0];
   assign w_add_cin = (r_state == ST_HI) ? r_carry : r_cin;

   rca_16 u_rca (
      .i_a    (w_add_a),
      .i_b    (w_add_b),
      .i_cin  (w_add_cin),
      .o_sum  (w_sum),
      .o_cout (w_cout),
      .o_ovf  (w_ovf)
   );

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         r_state     <= ST_IDLE;
         r_a         <= '0;
         r_b         <= '0;
         r_cin       <= 1'b0;
         r_carry     <= 1'b0;
         r_result    <= '0;
         r_cout      <= 1'b0;
         r_ovf       <= 1'b0;
         r_out_valid <= 1'b0;
         r_in_ready  <= 1'b1;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (in_valid) begin
                  // Subtraction is a + ~b + 1; the +1 rides in on the low-half carry.
                  r_a        <= operand_a;
                  r_b        <= operand_b ^ {OP_W{sub}};
                  r_cin      <= sub;
                  r_in_ready <= 1'b0;
                  r_state    <= ST_LO;
               end
            end
            ST_LO: begin
               r_result[HALF_W-1:0] <= w_sum;
               r_carry              <= w_cout;
               r_state              <= ST_HI;
            end
            ST_HI: begin
               r_result[OP_W-1:HALF_W] <= w_sum;
               r_cout                  <= w_cout;
               r_ovf                   <= w_ovf;
               r_out_valid             <= 1'b1;
               r_state                 <= ST_DONE;
            end
            ST_DONE: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_state     <= ST_IDLE;
               end
            end
            default: begin
               r_out_valid <= 1'b0;
               r_in_ready  <= 1'b1;
               r_state     <= ST_IDLE;
            end
         endcase
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign result    = r_result;
   assign cout      = r_cout;
   assign overflow  = r_ovf;
endmodule

// File: tb/tb_add32_seq.sv
// Directed self-checking bench for add32_seq with an expected-result queue.
module tb_add32_seq;
   logic        clock;
   logic        reset_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] operand_a;
   logic [31:0] operand_b;
   logic        sub;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
   logic        cout;
   logic        overflow;

   typedef struct {
      logic [31:0] r;
      logic        c;
      logic        o;
   } exp_t;

   exp_t sb_q[$];
   int   tests = 0;
   int   fails = 0;

   add32_seq dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .operand_a (operand_a),
      .operand_b (operand_b),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .cout      (cout),
      .overflow  (overflow)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog obs=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic s);
      logic [31:0] bb;
      logic [32:0] t;
      exp_t        e;
      bb  = s ? ~b : b;
      t   = {1'b0, a} + {1'b0, bb} + {32'd0, s};
      e.r = t[31:0];
      e.c = t[32];
      e.o = (a[31] == bb[31]) && (t[31] != a[31]);
      return e;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   // One full transaction; optionally stall 5 cycles in DONE with in_valid and noise.
   task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input exp_t e, input bit stall);
      exp_t got;
      check("in_ready_idle", {31'd0, in_ready}, 32'd1);
      operand_a = a;
      operand_b = b;
      sub       = s;
      in_valid  = 1'b1;
      sb_q.push_back(e);
      tick();
      in_valid  = 1'b0;
      operand_a = $urandom;
      operand_b = $urandom;
      sub       = ~s;
      out_ready = 1'b1;
      check("in_ready_busy", {31'd0, in_ready}, 32'd0);
      check("out_valid_lo", {31'd0, out_valid}, 32'd0);
      tick();
      check("out_valid_hi", {31'd0, out_valid}, 32'd0);
      if (stall) out_ready = 1'b0;
      tick();
      check("out_valid_done", {31'd0, out_valid}, 32'd1);
      check("sb_nonempty", {31'd0, (sb_q.size() != 0)}, 32'd1);
      if (sb_q.size() != 0) begin
         got = sb_q.pop_front();
         check("result", result, got.r);
         check("cout", {31'd0, cout}, {31'd0, got.c});
         check("overflow", {31'd0, overflow}, {31'd0, got.o});
         $display("[TB] op a=%h b=%h sub=%0d -> result=%h cout=%0d ovf=%0d",
                  a, b, s, result, cout, overflow);
      end
      if (stall) begin
         for (int i = 0; i < 5; i++) begin
            in_valid  = 1'b1;
            operand_a = $urandom;
            operand_b = $urandom;
            sub       = $urandom_range(0, 1);
            tick();
            check("stall_result", result, e.r);
            check("stall_flags", {30'd0, cout, overflow}, {30'd0, e.c, e.o});
            check("stall_valid", {31'd0, out_valid}, 32'd1);
            check("stall_in_ready", {31'd0, in_ready}, 32'd0);
         end
         in_valid  = 1'b0;
         out_ready = 1'b1;
      end
      tick();
      out_ready = 1'b0;
      check("out_valid_after_hs", {31'd0, out_valid}, 32'd0);
      check("in_ready_after_hs", {31'd0, in_ready}, 32'd1);
      check("result_retained", result, e.r);
   endtask

   initial begin
      exp_t    e;
      exp_t    got;
      logic [31:0] ra;
      logic [31:0] rb;
      logic        rs;
      int      n_res;
      int      last_c;

      reset_n   = 1'b0;
      in_valid  = 1'b0;
      operand_a = '0;
      operand_b = '0;
      sub       = 1'b0;
      out_ready = 1'b0;
      tick();
      tick();
      reset_n = 1'b1;
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_result", result, 32'd0);
      check("rst_flags", {30'd0, cout, overflow}, 32'd0);
      check("rst_in_ready", {31'd0, in_ready}, 32'd1);
      $display("[TB] reset released");

      run_op(32'h0000FFFF, 32'h00000001, 1'b0, '{32'h00010000, 1'b0, 1'b0}, 1'b0);
      run_op(32'h7FFFFFFF, 32'h00000001, 1'b0, '{32'h80000000, 1'b0, 1'b1}, 1'b0);
      run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, '{32'hFFFFFFFE, 1'b1, 1'b0}, 1'b0);
      run_op(32'h00000005, 32'h00000007, 1'b1, '{32'hFFFFFFFE, 1'b0, 1'b0}, 1'b0);
      run_op(32'h80000000, 32'h00000001, 1'b1, '{32'h7FFFFFFF, 1'b1, 1'b1}, 1'b0);
      run_op(32'h12345678, 32'h0FEDCBA9, 1'b0, '{32'h22222221, 1'b0, 1'b0}, 1'b1);

      for (int k = 0; k < 6; k++) begin
         ra = $urandom;
         rb = $urandom;
         rs = k[0];
         run_op(ra, rb, rs, model(ra, rb, rs), 1'b0);
      end

      // Reset while the high half is being computed.
      operand_a = 32'h12345678;
      operand_b = 32'h11111111;
      sub       = 1'b0;
      in_valid  = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
      check("midrst_result", result, 32'd0);
      check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
      tick();
      check("midrst_no_output", {31'd0, out_valid}, 32'd0);
      $display("[TB] reset in HI done");
      run_op(32'h00000001, 32'h00000001, 1'b0, '{32'h00000002, 1'b0, 1'b0}, 1'b0);

      // Back-to-back with both handshakes tied high.
      in_valid  = 1'b1;
      out_ready = 1'b1;
      n_res     = 0;
      last_c    = -1;
      for (int c = 0; c < 20; c++) begin
         if (in_ready) begin
            ra = $urandom;
            rb = $urandom;
            rs = c[2];
            operand_a = ra;
            operand_b = rb;
            sub       = rs;
            sb_q.push_back(model(ra, rb, rs));
         end
         tick();
         if (out_valid) begin
            check("b2b_sb_nonempty", {31'd0, (sb_q.size() != 0)}, 32'd1);
            if (sb_q.size() != 0) begin
               got = sb_q.pop_front();
               check("b2b_result", result, got.r);
               check("b2b_flags", {30'd0, cout, overflow}, {30'd0, got.c, got.o});
            end
            if (last_c >= 0) check("b2b_interval", c - last_c, 32'd4);
            $display("[TB] b2b cycle=%0d result=%h cout=%0d ovf=%0d", c, result, cout, overflow);
            last_c = c;
            n_res++;
            tick();
            c++;
            check("b2b_pulse_width", {31'd0, out_valid}, 32'd0);
         end
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      check("b2b_count", n_res, 32'd5);
      check("b2b_drained", sb_q.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
